// File: rtl/ev22_reg_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : ev22_reg_bank_if
// Brief    : Write, read-port and dump-stream signals of the ev22 register bank
// Revision : 1.0
// ============================================================================
interface ev22_reg_bank_if #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 6
);
  logic [DATA_W-1:0] wb_data;
  logic [SEL_W-1:0]  wb_sel;
  logic [SEL_W-1:0]  rd_sel_a;
  logic [SEL_W-1:0]  rd_sel_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic [DATA_W-1:0] w_out;
  logic              dump_start;
  logic              dump_valid;
  logic              dump_ready;
  logic [SEL_W-1:0]  dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              dump_busy;
  logic              dump_done;

  modport master (
    output wb_data, wb_sel, rd_sel_a, rd_sel_b, dump_start, dump_ready,
    input  rd_data_a, rd_data_b, w_out, dump_valid, dump_idx, dump_data,
           dump_busy, dump_done
  );

  modport slave (
    input  wb_data, wb_sel, rd_sel_a, rd_sel_b, dump_start, dump_ready,
    output rd_data_a, rd_data_b, w_out, dump_valid, dump_idx, dump_data,
           dump_busy, dump_done
  );
endinterface
`default_nettype wire

// File: rtl/ev22_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : ev22_reg_bank
// Brief    : 35-entry register bank (W at 34) with bypassed read ports and
//            a valid/ready debug dump sequencer
// Revision : 1.0
// ============================================================================
module ev22_reg_bank #(
  parameter int DATA_W   = 16,
  parameter int SEL_W    = 6,
  parameter int NUM_REGS = 35,
  parameter int W_INDEX  = 34,
  parameter int NULL_SEL = 35
) (
  input  wire logic      clk,
  input  wire logic      rst,
  ev22_reg_bank_if.slave bus
);
  localparam logic [SEL_W-1:0] c_num_regs = SEL_W'(NUM_REGS);
  localparam logic [SEL_W-1:0] c_last_idx = SEL_W'(NUM_REGS - 1);
  localparam logic [SEL_W-1:0] c_null_sel = SEL_W'(NULL_SEL);
  localparam logic [SEL_W-1:0] c_idx_one  = SEL_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  state_t            r_state;
  state_t            w_state_next;
  logic [SEL_W-1:0]  r_dump_idx;
  logic [SEL_W-1:0]  w_dump_idx_next;
  logic              w_wr_en;

  // The select alone qualifies a write; out-of-range selects are bubbles.
  assign w_wr_en = (bus.wb_sel < c_num_regs) && (bus.wb_sel != c_null_sel);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[bus.wb_sel] <= bus.wb_data;
    end
  end

  // Same-cycle forwarding so operand fetch sees the word being written back.
  assign bus.rd_data_a = (w_wr_en && (bus.rd_sel_a == bus.wb_sel)) ? bus.wb_data :
                         (bus.rd_sel_a < c_num_regs) ? r_regs[bus.rd_sel_a] : '0;
  assign bus.rd_data_b = (w_wr_en && (bus.rd_sel_b == bus.wb_sel)) ? bus.wb_data :
                         (bus.rd_sel_b < c_num_regs) ? r_regs[bus.rd_sel_b] : '0;
  assign bus.dump_data = (w_wr_en && (r_dump_idx == bus.wb_sel)) ? bus.wb_data :
                         (r_dump_idx < c_num_regs) ? r_regs[r_dump_idx] : '0;

  // W feeds back into writeback, so it must be the registered value.
  assign bus.w_out = r_regs[W_INDEX];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_dump_idx <= '0;
    end else begin
      r_state    <= w_state_next;
      r_dump_idx <= w_dump_idx_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_dump_idx_next = r_dump_idx;
    bus.dump_valid  = 1'b0;
    bus.dump_done   = 1'b0;
    bus.dump_busy   = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        bus.dump_busy = 1'b0;
        if (bus.dump_start) begin
          w_state_next    = ST_SEND;
          w_dump_idx_next = '0;
        end
      end
      ST_SEND: begin
        bus.dump_valid = 1'b1;
        if (bus.dump_ready) begin
          if (r_dump_idx == c_last_idx) begin
            w_state_next = ST_DONE;
          end else begin
            w_dump_idx_next = r_dump_idx + c_idx_one;
          end
        end
      end
      ST_DONE: begin
        bus.dump_done   = 1'b1;
        w_state_next    = ST_IDLE;
        w_dump_idx_next = '0;
      end
      default: begin
        w_state_next    = ST_IDLE;
        w_dump_idx_next = '0;
      end
    endcase
  end

  assign bus.dump_idx = r_dump_idx;
endmodule
`default_nettype wire

// File: tb/tb_ev22_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_ev22_reg_bank
// Brief    : Directed bench for ev22_reg_bank; dump words checked by scoreboard
// Revision : 1.0
// ============================================================================
module tb_ev22_reg_bank;
  typedef struct packed {
    logic [5:0]  idx;
    logic [15:0] data;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   done_count = 0;
  int   cycles;
  word_t exp_q[$];

  logic        hold_pending = 1'b0;
  logic [5:0]  hold_idx;
  logic [15:0] hold_data;

  always #5 clk = ~clk;

  ev22_reg_bank_if #(.DATA_W(16), .SEL_W(6)) bus ();

  ev22_reg_bank dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump(input logic [15:0] step);
    for (int i = 0; i < 35; i++) begin
      word_t w;
      logic [15:0] v;
      v = 16'(i) * step;
      w.idx  = 6'(i);
      w.data = v;
      exp_q.push_back(w);
    end
  endtask

  // Scoreboard monitor: pops one expected word per accepted dump beat.
  always @(negedge clk) begin
    word_t w;
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (bus.dump_done) begin
        done_count++;
        check("done_without_valid", 32'(bus.dump_valid), 32'd0);
      end
      if (bus.dump_valid) begin
        if (hold_pending) begin
          check("hold_idx", 32'(bus.dump_idx), 32'(hold_idx));
          check("hold_data", 32'(bus.dump_data), 32'(hold_data));
        end
        if (bus.dump_ready) begin
          hold_pending = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dump_unexpected: got idx %0d data %h, none expected", bus.dump_idx, bus.dump_data);
          end else begin
            w = exp_q.pop_front();
            check("dump_idx", 32'(bus.dump_idx), 32'(w.idx));
            check("dump_data", 32'(bus.dump_data), 32'(w.data));
          end
        end else begin
          hold_pending = 1'b1;
          hold_idx     = bus.dump_idx;
          hold_data    = bus.dump_data;
        end
      end else begin
        hold_pending = 1'b0;
      end
    end
  end

  initial begin
    int start_done;
    bus.wb_data    = 16'h0;
    bus.wb_sel     = 6'd35;
    bus.rd_sel_a   = 6'd0;
    bus.rd_sel_b   = 6'd0;
    bus.dump_start = 1'b0;
    bus.dump_ready = 1'b0;

    // Asynchronous reset asserted before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_rd_a", 32'(bus.rd_data_a), 32'd0);
    check("rst_rd_b", 32'(bus.rd_data_b), 32'd0);
    check("rst_w_out", 32'(bus.w_out), 32'd0);
    check("rst_dump_valid", 32'(bus.dump_valid), 32'd0);
    check("rst_dump_busy", 32'(bus.dump_busy), 32'd0);
    check("rst_dump_idx", 32'(bus.dump_idx), 32'd0);
    check("rst_dump_done", 32'(bus.dump_done), 32'd0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Basic write then read.
    bus.wb_sel  = 6'd5;
    bus.wb_data = 16'h1234;
    tick();
    bus.wb_sel   = 6'd63;
    bus.rd_sel_a = 6'd5;
    #1 check("write_read_5", 32'(bus.rd_data_a), 32'h1234);

    // Bypass on both ports; out-of-range read.
    bus.wb_sel   = 6'd7;
    bus.wb_data  = 16'hBEEF;
    bus.rd_sel_a = 6'd7;
    bus.rd_sel_b = 6'd7;
    #1;
    check("bypass_a", 32'(bus.rd_data_a), 32'hBEEF);
    check("bypass_b", 32'(bus.rd_data_b), 32'hBEEF);
    bus.rd_sel_a = 6'd40;
    bus.rd_sel_b = 6'd5;
    #1;
    check("read_sel_40", 32'(bus.rd_data_a), 32'd0);
    check("read_other_during_write", 32'(bus.rd_data_b), 32'h1234);
    tick();

    // W path: registered, no bypass, back-to-back.
    bus.wb_sel  = 6'd34;
    bus.wb_data = 16'h00A5;
    #1 check("w_no_bypass", 32'(bus.w_out), 32'd0);
    tick();
    check("w_t1", 32'(bus.w_out), 32'h00A5);
    bus.wb_data = 16'h5A00;
    tick();
    check("w_t2", 32'(bus.w_out), 32'h5A00);

    // Preload reg[i] = i * 0x0101.
    for (int i = 0; i < 35; i++) begin
      bus.wb_sel  = 6'(i);
      bus.wb_data = 16'(i) * 16'h0101;
      tick();
    end

    // Null selects write nothing; index 35 never bypasses.
    bus.wb_data  = 16'hFFFF;
    bus.wb_sel   = 6'd35;
    bus.rd_sel_a = 6'd35;
    #1 check("read_35_null_write", 32'(bus.rd_data_a), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    bus.wb_sel = 6'd63;
    for (int i = 0; i < 3; i++) tick();
    bus.rd_sel_a = 6'd34;
    #1 check("w_after_null", 32'(bus.rd_data_a), 32'h2222);

    // Dump with ready toggling; a stray start mid-dump must be ignored.
    push_dump(16'h0101);
    start_done = done_count;
    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    check("dump_busy_send", 32'(bus.dump_busy), 32'd1);
    check("dump_first_idx", 32'(bus.dump_idx), 32'd0);
    cycles = 0;
    while (done_count == start_done && cycles < 300) begin
      bus.dump_ready = ~bus.dump_ready;
      bus.dump_start = (cycles == 10);
      tick();
      cycles++;
    end
    bus.dump_start = 1'b0;
    bus.dump_ready = 1'b0;
    if (cycles >= 300) begin
      checks++;
      errors++;
      $display("FAIL dump1_timeout: got no dump_done after %0d cycles", cycles);
    end
    tick();
    tick();
    check("dump1_done_once", 32'(done_count - start_done), 32'd1);
    check("dump1_queue_empty", 32'(exp_q.size()), 32'd0);
    check("dump1_busy_idle", 32'(bus.dump_busy), 32'd0);

    // Reset mid-dump at index 12.
    for (int i = 0; i < 12; i++) begin
      word_t w;
      w.idx  = 6'(i);
      w.data = 16'(i) * 16'h0101;
      exp_q.push_back(w);
    end
    start_done     = done_count;
    bus.dump_ready = 1'b1;
    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    cycles = 0;
    while (bus.dump_idx != 6'd12 && cycles < 60) begin
      tick();
      cycles++;
    end
    if (cycles >= 60) begin
      checks++;
      errors++;
      $display("FAIL dump2_idx12_timeout: got idx %0d, required 12", bus.dump_idx);
    end
    #1 rst = 1'b1;
    #1;
    check("midrst_valid", 32'(bus.dump_valid), 32'd0);
    check("midrst_busy", 32'(bus.dump_busy), 32'd0);
    check("midrst_idx", 32'(bus.dump_idx), 32'd0);
    bus.rd_sel_a = 6'd5;
    #1 check("midrst_reg_cleared", 32'(bus.rd_data_a), 32'd0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("midrst_no_done", 32'(done_count - start_done), 32'd0);
    check("midrst_queue_empty", 32'(exp_q.size()), 32'd0);

    // Fresh dump after reset restarts at idx 0, full throughput.
    push_dump(16'h0000);
    start_done     = done_count;
    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    check("dump3_first_idx", 32'(bus.dump_idx), 32'd0);
    cycles = 0;
    while (done_count == start_done && cycles < 100) begin
      tick();
      cycles++;
    end
    check("dump3_cycles", 32'(cycles), 32'd36);
    check("dump3_done_once", 32'(done_count - start_done), 32'd1);
    check("dump3_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ev22_reg_bank.md
Name: ev22_reg_bank

Overview:
- Register bank directly downstream of the writeback stage.
- Consumes the writeback stage's registered DATA/SEL_REG pair each clock and holds 34 general registers plus the working register W at index 34.
- Provides two combinational read ports for the operand fetch stage, and a continuous W output that feeds the writeback stage's W_IN.
- Includes a debug dump sequencer that streams all registers out over a valid/ready handshake.

Parameters:
DATA_W, 16, register width in bits
SEL_W, 6, register select width
NUM_REGS, 35, implemented registers (indices 0..NUM_REGS-1)
W_INDEX, 34, index of the working register W
NULL_SEL, 35, select value meaning "no write"

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
wb_data  in  DATA_W  write data from the writeback stage (its DATA output)
wb_sel  in  SEL_W  write select from the writeback stage (its SEL_REG output)
rd_sel_a  in  SEL_W  read port A select
rd_sel_b  in  SEL_W  read port B select
rd_data_a  out  DATA_W  read port A data
rd_data_b  out  DATA_W  read port B data
w_out  out  DATA_W  current W register contents
dump_start  in  1  single-cycle request to start a register dump
dump_valid  out  1  dump word valid
dump_ready  in  1  consumer accepts the dump word
dump_idx  out  SEL_W  index of the current dump word
dump_data  out  DATA_W  value of the current dump word
dump_busy  out  1  high while the dump sequencer is not IDLE
dump_done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
Reset and clocking:
- One clock (clk); reset rst is asynchronous, active-high.
- While rst is high: all registers = 0, state = IDLE, dump_valid = 0, dump_done = 0, dump_idx = 0, dump_busy = 0.
- rd_data_a/b, w_out and dump_data are combinational, so all read 0 under reset.

Write port:
- At each rising clk, if wb_sel < NUM_REGS, reg[wb_sel] <= wb_data.
- wb_sel >= NUM_REGS (including NULL_SEL = 35 and 36..63) writes nothing.
- There is no separate write enable; the select alone decides.

Read ports:
- Fully combinational.
- rd_data_x = wb_data when rd_sel_x == wb_sel and wb_sel < NUM_REGS (write-through bypass, same-cycle forwarding).
- Otherwise rd_data_x = reg[rd_sel_x] when rd_sel_x < NUM_REGS, else 0.
- Ports A and B are independent; both may address the same register.

W output:
- w_out = reg[W_INDEX], without bypass, so it is the registered value.
- A write to W_INDEX appears on w_out one cycle after it is presented.

Dump FSM (states IDLE, SEND, DONE):
- IDLE: dump_start=1 -> SEND with dump_idx=0.
- SEND:
  - dump_valid=1 and dump_data follows the read-port bypass rule for dump_idx.
  - dump_data and dump_idx must be held stable until dump_valid && dump_ready.
  - On accept with dump_idx < NUM_REGS-1: dump_idx increments and the state stays SEND.
  - On accept with dump_idx == NUM_REGS-1: -> DONE.
- DONE: dump_done=1 for exactly one cycle, dump_valid=0, then -> IDLE with dump_idx=0.
- dump_start is ignored outside IDLE.
- Writes proceed normally during a dump. A dumped word reflects the contents at the accepting edge, with bypass.
- rst asserted mid-dump returns to IDLE immediately, with no dump_done.
- dump_busy = (state != IDLE).
- Throughput with dump_ready held high: one word per cycle, so 35 cycles of dump_valid plus 1 DONE cycle.

Boundary conditions:
- Simultaneous write and read of the same index: the read returns the new data.
- Write to index 35: no register changes, and a read of 35 still returns 0.
- Back-to-back writes to W_INDEX on consecutive cycles: w_out shows each value one cycle later, in order.
- dump_ready low for N cycles: the word is held stable and the index does not advance.

Test Plan:
- Reset: rst=1 async mid-cycle -> all read ports, w_out = 0, dump_valid = 0. Release, then write wb_sel=5, wb_data=16'h1234 -> next cycle rd_sel_a=5 returns 16'h1234.
- Bypass: same cycle wb_sel=7, wb_data=16'hBEEF, rd_sel_a=rd_sel_b=7 -> both read 16'hBEEF combinationally. rd_sel_a=40 -> 0.
- Null select: wb_sel=35, wb_data=16'hFFFF for 3 cycles -> all 35 registers unchanged, verified by dump. wb_sel=63 likewise.
- W path: wb_sel=34, wb_data=16'h00A5 at cycle t -> w_out = 16'h00A5 from cycle t+1. Then wb_sel=34, wb_data=16'h5A00 at t+1 -> w_out = 16'h5A00 at t+2.
- Dump with backpressure: preload reg[i] = i*16'h0101. Pulse dump_start; toggle dump_ready every other cycle -> 35 accepted words, idx 0..34, data = idx*16'h0101. Words are stable while ready is low. dump_done pulses exactly once, and dump_start during SEND is ignored.
- Reset mid-dump: assert rst at dump_idx=12 -> dump_valid drops, dump_busy=0, no dump_done. A new dump_start after release restarts at idx 0.
